// File: rtl/dff_piso_tx_param_pkg.sv
// Shared types for the PISO transmitter and its bit counter.
// Also used by the matching SIPO receiver.
package dff_piso_tx_param_pkg;

  localparam int unsigned PISO_WIDTH = 6;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } piso_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_piso_tx_param_bit_counter.sv
// Modulo-WIDTH up-counter with sync clear, enable and
// terminal-count flag; wraps to zero after WIDTH-1.
module bit_counter_param
  import dff_piso_tx_param_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH,
  localparam int unsigned CW = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dff_piso_tx_param.sv
// Parallel-in/serial-out transmitter with valid/last framing
// and zero-gap back-to-back word reload.
module dff_piso_tx_param
  import dff_piso_tx_param_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW = cnt_w(WIDTH);

  piso_state_e      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             is_shift;
  logic             strike;
  logic             accept;
  logic             head_bit;

  assign is_shift   = (state_q == S_SHIFT);
  assign strike     = is_shift & shift_en;
  assign load_ready = ~is_shift | (tc & shift_en);
  assign accept     = load_valid & load_ready;

  bit_counter_param #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept | (strike & tc)),
    .en_i  (strike & ~tc),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  always_comb begin
    shreg_d  = shreg_q;
    head_bit = shreg_q[0];
    if (MSB_FIRST) begin
      shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
      head_bit = shreg_q[WIDTH-1];
    end else begin
      shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // accept also covers the last-bit reload, so arms are disjoint
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          shreg_q <= load_data;
          state_q <= S_SHIFT;
        end
        (strike & tc & ~load_valid): begin
          state_q <= S_IDLE;
        end
        (strike & ~tc): begin
          shreg_q <= shreg_d;
        end
        default: begin
        end
      endcase
    end
  end

  assign ser_valid = is_shift;
  assign busy      = is_shift;
  assign ser_last  = is_shift & tc;
  assign ser_out   = is_shift ? head_bit : IDLE_BIT;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_dff_piso_tx_param.sv
// Bench: MSB-first and LSB-first instances vs a word/index model.
module tb_dff_piso_tx_param;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         shift_en = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;

  logic rdy_m, out_m, val_m, last_m, busy_m;
  logic rdy_l, out_l, val_l, last_l, busy_l;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dff_piso_tx_param #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) u_msb (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en),
    .load_valid(load_valid), .load_ready(rdy_m),
    .load_data(load_data), .ser_out(out_m),
    .ser_valid(val_m), .ser_last(last_m), .busy(busy_m)
  );

  dff_piso_tx_param #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) u_lsb (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en),
    .load_valid(load_valid), .load_ready(rdy_l),
    .load_data(load_data), .ser_out(out_l),
    .ser_valid(val_l), .ser_last(last_l), .busy(busy_l)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: word in flight plus index of the bit on the line
  logic [W-1:0] m_word = '0;
  int           m_k = 0;
  bit           m_act = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_k   <= 0;
    end else if (!m_act) begin
      if (load_valid) begin
        m_word <= load_data;
        m_k    <= 0;
        m_act  <= 1'b1;
      end
    end else if (shift_en) begin
      if (m_k == W - 1) begin
        if (load_valid) begin
          m_word <= load_data;
          m_k    <= 0;
        end else begin
          m_act <= 1'b0;
        end
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic e_rdy, e_last, e_om, e_ol;
    #2;
    if (chk_en) begin
      e_rdy  = !m_act || (m_k == W - 1 && shift_en);
      e_last = m_act && (m_k == W - 1);
      e_om   = m_act ? m_word[W-1-m_k] : 1'b0;
      e_ol   = m_act ? m_word[m_k] : 1'b1;
      chk("m_ready", 32'(rdy_m), 32'(e_rdy));
      chk("m_valid", 32'(val_m), 32'(m_act));
      chk("m_busy", 32'(busy_m), 32'(m_act));
      chk("m_last", 32'(last_m), 32'(e_last));
      chk("m_out", 32'(out_m), 32'(e_om));
      chk("l_ready", 32'(rdy_l), 32'(e_rdy));
      chk("l_valid", 32'(val_l), 32'(m_act));
      chk("l_last", 32'(last_l), 32'(e_last));
      chk("l_out", 32'(out_l), 32'(e_ol));
    end
  end

  task automatic drive(input logic r, input logic lv,
                       input logic [W-1:0] d, input logic se);
    @(negedge clk);
    rst_n      = r;
    load_valid = lv;
    load_data  = d;
    shift_en   = se;
  endtask

  initial begin
    logic [W-1:0] sm, sl;
    logic [11:0]  s12;
    int nv, nl, nr, dens;

    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    chk_en = 1'b1;
    drive(1, 0, '0, 1);
    #3;
    chk("rst_ready", 32'(rdy_m), 32'd1);
    chk("rst_valid", 32'(val_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_out_m", 32'(out_m), 32'd0);
    chk("rst_out_l", 32'(out_l), 32'd1);

    // single word, full rate
    drive(1, 1, 6'b101100, 1);
    sm = '0; sl = '0; nl = 0; nr = 0;
    for (int i = 0; i < W; i++) begin
      drive(1, 0, '0, 1);
      #3;
      sm = {sm[W-2:0], out_m};
      sl = {sl[W-2:0], out_l};
      nl += int'(last_m);
      nr += int'(rdy_m);
    end
    chk("single_msb_seq", 32'(sm), 32'(6'b101100));
    chk("single_lsb_seq", 32'(sl), 32'(6'b001101));
    chk("single_last_cnt", 32'(nl), 32'd1);
    chk("single_last_at6", 32'(last_m), 32'd1);
    chk("single_rdy_cnt", 32'(nr), 32'd1);
    drive(1, 0, '0, 1);
    #3;
    chk("single_idle_valid", 32'(val_m), 32'd0);
    chk("single_idle_ready", 32'(rdy_m), 32'd1);

    // back-to-back words
    drive(1, 1, 6'h3F, 1);
    s12 = '0; nv = 0; nr = 0;
    for (int i = 0; i < 2 * W; i++) begin
      drive(1, (i <= W - 1), (i < W - 1) ? 6'h3F : 6'h15, 1);
      #3;
      s12 = {s12[10:0], out_m};
      nv += int'(val_m);
      nr += int'(rdy_m);
      if (i == W - 1) chk("b2b_ready_mid", 32'(rdy_m), 32'd1);
    end
    chk("b2b_seq", 32'(s12), 32'hFD5);
    chk("b2b_valid_cnt", 32'(nv), 32'd12);
    chk("b2b_ready_cnt", 32'(nr), 32'd2);
    drive(1, 0, '0, 1);
    #3;
    chk("b2b_idle", 32'(val_m), 32'd0);

    // shift_en every third cycle
    drive(1, 1, 6'b100001, 1);
    nv = 0; nl = 0;
    for (int i = 0; i < 21; i++) begin
      drive(1, 0, '0, (i % 3 == 2));
      #3;
      nv += int'(val_m);
      nl += int'(last_m);
    end
    chk("slow_valid_cnt", 32'(nv), 32'd18);
    chk("slow_last_cnt", 32'(nl), 32'd3);

    // reset mid-word then a clean word
    drive(1, 1, 6'b110101, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, '0, 1);
    drive(0, 0, '0, 1);
    drive(1, 0, '0, 1);
    #3;
    chk("abort_valid", 32'(val_m), 32'd0);
    chk("abort_busy", 32'(busy_l), 32'd0);
    chk("abort_out_m", 32'(out_m), 32'd0);
    chk("abort_out_l", 32'(out_l), 32'd1);
    drive(1, 1, 6'b011010, 1);
    sm = '0; sl = '0;
    for (int i = 0; i < W; i++) begin
      drive(1, 0, '0, 1);
      #3;
      sm = {sm[W-2:0], out_m};
      sl = {sl[W-2:0], out_l};
    end
    chk("post_abort_msb", 32'(sm), 32'(6'b011010));
    chk("post_abort_lsb", 32'(sl), 32'(6'b010110));

    // randomized traffic, model-checked every cycle
    dens = 100;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) dens = (n / 500 % 3 == 0) ? 100 :
                               (n / 500 % 3 == 1) ? 50 : 20;
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0),
            W'($urandom),
            ($urandom_range(0, 99) < dens));
    end
    drive(1, 0, '0, 1);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
